// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: buffer enables/flushes, PC control, wide-access and interrupt entry.
// Optional stall counter built only when HAZ_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_memWide,
  input  logic             i_loadUse,
  input  logic             i_branchTaken,
  input  logic             i_intReq,
  output logic             o_en_IFID,
  output logic             o_en_IDEX,
  output logic             o_en_EXMEM,
  output logic             o_en_MEMWB,
  output logic             o_fl_IFID,
  output logic             o_fl_IDEX,
  output logic             o_fl_EXMEM,
  output logic             o_fl_MEMWB,
  output logic             o_pcWrite,
  output logic [1:0]       o_pcSel,
  output logic             o_memHalf,
  output logic             o_intPush,
  output logic             o_intAck,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_stallCount
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_MEM2   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_PUSH_H = 3'd4;
  localparam logic [2:0] S_PUSH_L = 3'd5;
  localparam logic [2:0] S_VEC    = 3'd6;

  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_VEC = 2'b10;
  localparam logic [1:0] PC_RST = 2'b11;

  logic [2:0] state_q, state_d;
  logic       int_pending_q, int_pending_d;
  logic [2:0] drain_q, drain_d;
  logic       half_q, half_d;

  // Buffer strobes packed as {IFID, IDEX, EXMEM, MEMWB}.
  logic [3:0] en, fl;
  logic       pc_write, mem_half, int_push, int_ack, apply_hazard;
  logic [1:0] pc_sel;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    drain_d      = drain_q;
    half_d       = 1'b0;
    en           = 4'b0000;
    fl           = 4'b0000;
    pc_write     = 1'b0;
    pc_sel       = PC_INC;
    mem_half     = 1'b0;
    int_push     = 1'b0;
    int_ack      = 1'b0;
    apply_hazard = 1'b0;

    case (state_q)
      S_BOOT: begin
        fl       = 4'b1111;
        pc_write = 1'b1;
        pc_sel   = PC_RST;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (i_memWide) begin
          en      = 4'b0001;
          fl      = 4'b0001;
          state_d = S_MEM2;
        end else if (int_pending_q) begin
          en      = 4'b0111;
          fl      = 4'b1000;
          drain_d = 3'(DRAIN_CYCLES - 1);
          state_d = S_DRAIN;
        end else begin
          apply_hazard = 1'b1;
        end
      end
      S_MEM2: begin
        mem_half     = 1'b1;
        apply_hazard = 1'b1;
        state_d      = S_RUN;
      end
      S_DRAIN: begin
        en = 4'b0011;
        fl = 4'b1100;
        // A wide access in flight finishes both halves before the counter moves on.
        if (i_memWide) begin
          mem_half = half_q;
          half_d   = ~half_q;
          if (!half_q) begin
            en = 4'b0001;
            fl = 4'b1101;
          end
        end else if (drain_q == 3'd0) begin
          state_d = S_PUSH_H;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      S_PUSH_H, S_PUSH_L: begin
        int_push = 1'b1;
        mem_half = (state_q == S_PUSH_H);
        en       = 4'b0001;
        fl       = 4'b0010;
        state_d  = (state_q == S_PUSH_H) ? S_PUSH_L : S_VEC;
      end
      S_VEC: begin
        en       = 4'b0011;
        fl       = 4'b1100;
        pc_write = 1'b1;
        pc_sel   = PC_VEC;
        int_ack  = 1'b1;
        state_d  = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase

    // Normal flow shared by RUN and MEM2; a taken branch outranks a load-use stall.
    if (apply_hazard) begin
      en       = 4'b1111;
      pc_write = 1'b1;
      if (i_branchTaken) begin
        fl     = 4'b1100;
        pc_sel = PC_BR;
      end else if (i_loadUse) begin
        en       = 4'b0111;
        fl       = 4'b0100;
        pc_write = 1'b0;
      end
    end

    int_pending_d = i_intReq | (int_pending_q & (state_d != S_VEC));

    // Outputs feed the buffers directly, so reset must force them without waiting for a clock.
    if (!rst) begin
      en       = 4'b0000;
      fl       = 4'b1111;
      pc_write = 1'b0;
      pc_sel   = PC_RST;
      mem_half = 1'b0;
      int_push = 1'b0;
      int_ack  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_BOOT;
      int_pending_q <= 1'b0;
      drain_q       <= 3'd0;
      half_q        <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignment so every flop samples pre-edge values.
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
      drain_q       <= drain_d;
      half_q        <= half_d;
    end
  end

  assign {o_en_IFID, o_en_IDEX, o_en_EXMEM, o_en_MEMWB} = en;
  assign {o_fl_IFID, o_fl_IDEX, o_fl_EXMEM, o_fl_MEMWB} = fl;
  assign o_pcWrite = pc_write;
  assign o_pcSel   = pc_sel;
  assign o_memHalf = mem_half;
  assign o_intPush = int_push;
  assign o_intAck  = int_ack;
  assign o_state   = state_q;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (state_q != S_BOOT) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign o_stallCount = stall_cnt_q;
`else
  assign o_stallCount = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, wide access, branch, interrupt entry, reset mid-push.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 16;
`ifdef HAZ_STALL_CNT_EN
  localparam int STALL_AFTER_LU = 1;
`else
  localparam int STALL_AFTER_LU = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_memWide = 1'b0, i_loadUse = 1'b0, i_branchTaken = 1'b0, i_intReq = 1'b0;
  logic o_en_IFID, o_en_IDEX, o_en_EXMEM, o_en_MEMWB;
  logic o_fl_IFID, o_fl_IDEX, o_fl_EXMEM, o_fl_MEMWB;
  logic o_pcWrite, o_memHalf, o_intPush, o_intAck;
  logic [1:0] o_pcSel;
  logic [2:0] o_state;
  logic [CNT_W-1:0] o_stallCount;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_memWide(i_memWide), .i_loadUse(i_loadUse),
    .i_branchTaken(i_branchTaken), .i_intReq(i_intReq),
    .o_en_IFID(o_en_IFID), .o_en_IDEX(o_en_IDEX), .o_en_EXMEM(o_en_EXMEM), .o_en_MEMWB(o_en_MEMWB),
    .o_fl_IFID(o_fl_IFID), .o_fl_IDEX(o_fl_IDEX), .o_fl_EXMEM(o_fl_EXMEM), .o_fl_MEMWB(o_fl_MEMWB),
    .o_pcWrite(o_pcWrite), .o_pcSel(o_pcSel), .o_memHalf(o_memHalf),
    .o_intPush(o_intPush), .o_intAck(o_intAck),
    .o_state(o_state), .o_stallCount(o_stallCount)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compares every control output; strobes are {IFID, IDEX, EXMEM, MEMWB}.
  task automatic chk_all(input string tag, input logic [2:0] st, input logic [3:0] en,
                         input logic [3:0] fl, input logic pcw, input logic [1:0] pcs,
                         input logic mh, input logic push, input logic ack);
    check({tag, "/state"}, 32'(o_state), 32'(st));
    check({tag, "/en"}, 32'({o_en_IFID, o_en_IDEX, o_en_EXMEM, o_en_MEMWB}), 32'(en));
    check({tag, "/fl"}, 32'({o_fl_IFID, o_fl_IDEX, o_fl_EXMEM, o_fl_MEMWB}), 32'(fl));
    check({tag, "/pcWrite"}, 32'(o_pcWrite), 32'(pcw));
    check({tag, "/pcSel"}, 32'(o_pcSel), 32'(pcs));
    check({tag, "/memHalf"}, 32'(o_memHalf), 32'(mh));
    check({tag, "/intPush"}, 32'(o_intPush), 32'(push));
    check({tag, "/intAck"}, 32'(o_intAck), 32'(ack));
  endtask

  // Apply inputs just after a posedge, check at the negedge, advance past the next posedge.
  task automatic step(input logic mw, input logic lu, input logic br, input logic ir,
                      input string tag, input logic [2:0] st, input logic [3:0] en,
                      input logic [3:0] fl, input logic pcw, input logic [1:0] pcs,
                      input logic mh, input logic push, input logic ack);
    i_memWide = mw; i_loadUse = lu; i_branchTaken = br; i_intReq = ir;
    @(negedge clk);
    chk_all(tag, st, en, fl, pcw, pcs, mh, push, ack);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk_all("reset", 3'd0, 4'b0000, 4'b1111, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    check("reset/stall", 32'(o_stallCount), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    step(0,0,0,0, "boot",   3'd0, 4'b0000, 4'b1111, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "run",    3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("stall/before_lu", 32'(o_stallCount), 32'd0);

    step(0,1,0,0, "loaduse", 3'd1, 4'b0111, 4'b0100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "lu_done", 3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    check("stall/after_lu", 32'(o_stallCount), 32'(STALL_AFTER_LU));

    step(1,0,0,0, "wide1",  3'd1, 4'b0001, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "wide2",  3'd2, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    step(0,0,0,0, "wide3",  3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    step(0,1,1,0, "br_lu",  3'd1, 4'b1111, 4'b1100, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);

    step(0,0,0,1, "irq_pulse", 3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "irq_run",   3'd1, 4'b0111, 4'b1000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "irq_drn1",  3'd3, 4'b0011, 4'b1100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "irq_drn2",  3'd3, 4'b0011, 4'b1100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "irq_pushh", 3'd4, 4'b0001, 4'b0010, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
    step(0,0,0,0, "irq_pushl", 3'd5, 4'b0001, 4'b0010, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
    step(0,0,0,0, "irq_vec",   3'd6, 4'b0011, 4'b1100, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
    step(0,0,0,0, "irq_back",  3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    // Pulse during MEM2 waits for RUN, then enters the sequence.
    step(1,0,0,0, "m2_wide",  3'd1, 4'b0001, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,1, "m2_pulse", 3'd2, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    step(0,0,0,0, "m2_run",   3'd1, 4'b0111, 4'b1000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "m2_drn1",  3'd3, 4'b0011, 4'b1100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "m2_drn2",  3'd3, 4'b0011, 4'b1100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

    #2;
    check("mid/state", 32'(o_state), 32'd4);
    check("mid/push",  32'(o_intPush), 32'd1);
    rst = 1'b0;
    #1;
    chk_all("mid_rst", 3'd0, 4'b0000, 4'b1111, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step(0,0,0,0, "rb_boot", 3'd0, 4'b0000, 4'b1111, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "rb_run1", 3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    step(0,0,0,0, "rb_run2", 3'd1, 4'b1111, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
